// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Pipeline hazard scoreboard. Tracks the destination register of
//               every instruction issued past ID for STAGES cycles. It raises a
//               load-use / HI-LO interlock stall and selects the youngest
//               forwarding source for each ID operand.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   STAGES   tracked in-flight stages after ID (1..7), entry 1 = youngest
//   AW       register address width
//   MW       multi-cycle-unit latency field width
//   FW       derived forwarding-select width, clog2(STAGES+1)
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   id_valid       in   ID holds a real instruction
//   id_rs/id_rt    in   source register addresses
//   id_rs_used/_rt in   source is actually read
//   id_wen         in   ID writes the register file
//   id_lw          in   ID is a load
//   id_waddr       in   ID destination register
//   id_hilo        in   ID reads HI/LO
//   id_mdu_start   in   ID launches a mult/div
//   id_mdu_cycles  in   mult/div latency in cycles
//   flush          in   kill all tracked in-flight instructions
//   stall          out  hold PC and IF/ID, insert a bubble (combinational)
//   fwd_a/fwd_b    out  0 = register file, k = forward from tracked stage k
//   mdu_busy       out  multi-cycle unit busy
//   stall_cnt      out  accumulated stall cycles
// Configuration
//   HAZARD_PERF_EN  defined: stall_cnt counts stall cycles, saturating.
//                   undefined: stall_cnt is tied to zero, no counter flops.
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
   parameter int STAGES = 3,
   parameter int AW     = 5,
   parameter int MW     = 6,
   localparam int FW    = $clog2(STAGES + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic          id_rs_used,
   input  logic          id_rt_used,
   input  logic          id_wen,
   input  logic          id_lw,
   input  logic [AW-1:0] id_waddr,
   input  logic          id_hilo,
   input  logic          id_mdu_start,
   input  logic [MW-1:0] id_mdu_cycles,
   input  logic          flush,
   output logic          stall,
   output logic [FW-1:0] fwd_a,
   output logic [FW-1:0] fwd_b,
   output logic          mdu_busy,
   output logic [31:0]   stall_cnt
);

   localparam logic [31:0] c_cnt_max = 32'hFFFF_FFFF;

   // ------------------------------------------------------------------------
   // Scoreboard storage. Bit/element 0 holds entry 1 (the youngest).
   // ------------------------------------------------------------------------
   logic [STAGES-1:0] r_valid;
   logic [STAGES-1:0] r_lw;
   logic [AW-1:0]     r_waddr [STAGES];
   logic [MW-1:0]     r_mdu_cnt;

   logic [STAGES-1:0] w_match_a;
   logic [STAGES-1:0] w_match_b;
   logic              w_load_use;
   logic              w_mdu_busy;
   logic              w_stall;
   logic              w_issue;
   logic [FW-1:0]     w_fwd_a;
   logic [FW-1:0]     w_fwd_b;

   // ------------------------------------------------------------------------
   // Per-entry source matching. Register 0 is hard-wired and never matches.
   // ------------------------------------------------------------------------
   generate
      for (genvar g = 0; g < STAGES; g++) begin : g_match
         assign w_match_a[g] = id_rs_used && (id_rs != '0) && r_valid[g] &&
                               (r_waddr[g] == id_rs);
         assign w_match_b[g] = id_rt_used && (id_rt != '0) && r_valid[g] &&
                               (r_waddr[g] == id_rt);
      end
   endgenerate

   assign w_load_use = |((w_match_a | w_match_b) & r_lw);
   assign w_mdu_busy = (r_mdu_cnt != '0);

   // A load result is only usable after it leaves the tracked window, so any
   // match against a load stalls; HI/LO readers and new mult/div launches
   // wait for the multi-cycle unit to drain.
   assign w_stall = id_valid &&
                    (w_load_use || ((id_hilo || id_mdu_start) && w_mdu_busy));

   // A stalled instruction enters the pipeline as a bubble.
   assign w_issue = id_valid && id_wen && !w_stall;

   // ------------------------------------------------------------------------
   // Forwarding select: scan oldest to youngest so the youngest match wins.
   // ------------------------------------------------------------------------
   always_comb begin
      w_fwd_a = '0;
      w_fwd_b = '0;
      if (!w_stall) begin
         for (int k = STAGES - 1; k >= 0; k--) begin
            if (w_match_a[k]) begin
               w_fwd_a = FW'(k + 1);
            end
            if (w_match_b[k]) begin
               w_fwd_b = FW'(k + 1);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Valid bits: shift toward the oldest entry; flush wipes every entry,
   // including the one that would have been issued on this edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (flush) begin
         r_valid <= '0;
      end else begin
         for (int k = 1; k < STAGES; k++) begin
            r_valid[k] <= r_valid[k-1];
         end
         r_valid[0] <= w_issue;
      end
   end

   // Address and load tag travel with the valid bit; they are meaningless
   // while the matching valid bit is low, so they shift unconditionally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lw <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_waddr[k] <= '0;
         end
      end else begin
         for (int k = 1; k < STAGES; k++) begin
            r_lw[k]    <= r_lw[k-1];
            r_waddr[k] <= r_waddr[k-1];
         end
         r_lw[0]    <= id_lw;
         r_waddr[0] <= id_waddr;
      end
   end

   // ------------------------------------------------------------------------
   // Multi-cycle unit countdown. Launch is blocked by stall, so a new
   // mult/div can never overwrite a running one.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mdu_cnt <= '0;
      end else if (flush) begin
         r_mdu_cnt <= '0;
      end else if (id_valid && id_mdu_start && !w_stall) begin
         r_mdu_cnt <= id_mdu_cycles;
      end else if (w_mdu_busy) begin
         r_mdu_cnt <= r_mdu_cnt - MW'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Stall-cycle performance counter
   // ------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != c_cnt_max)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = c_cnt_max & 32'd0;
`endif

   assign stall    = w_stall;
   assign fwd_a    = w_fwd_a;
   assign fwd_b    = w_fwd_b;
   assign mdu_busy = w_mdu_busy;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard (STAGES=3). A table
//               of per-cycle ID inputs with hand-computed expected outputs is
//               applied one vector per clock, followed by hand-written reset
//               and performance-counter sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

   localparam int STAGES = 3;
   localparam int AW     = 5;
   localparam int MW     = 6;
   localparam int FW     = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          id_valid;
   logic [AW-1:0] id_rs, id_rt;
   logic          id_rs_used, id_rt_used;
   logic          id_wen, id_lw;
   logic [AW-1:0] id_waddr;
   logic          id_hilo, id_mdu_start;
   logic [MW-1:0] id_mdu_cycles;
   logic          flush;
   logic          stall;
   logic [FW-1:0] fwd_a, fwd_b;
   logic          mdu_busy;
   logic [31:0]   stall_cnt;

   int n_total = 0;
   int n_pass  = 0;

   hazard_scoreboard #(.STAGES(STAGES), .AW(AW), .MW(MW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_rs_used    (id_rs_used),
      .id_rt_used    (id_rt_used),
      .id_wen        (id_wen),
      .id_lw         (id_lw),
      .id_waddr      (id_waddr),
      .id_hilo       (id_hilo),
      .id_mdu_start  (id_mdu_start),
      .id_mdu_cycles (id_mdu_cycles),
      .flush         (flush),
      .stall         (stall),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b),
      .mdu_busy      (mdu_busy),
      .stall_cnt     (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic [AW-1:0] rs;
      logic          rsu;
      logic [AW-1:0] rt;
      logic          rtu;
      logic          wen;
      logic          lw;
      logic [AW-1:0] wa;
      logic          hilo;
      logic          ms;
      logic [MW-1:0] mc;
      logic          fl;
      logic          e_stall;
      logic [FW-1:0] e_fa;
      logic [FW-1:0] e_fb;
      logic          e_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic v, input int rs, input logic rsu, input int rt, input logic rtu,
      input logic wen, input logic lw, input int wa, input logic hilo,
      input logic ms, input int mc, input logic fl,
      input logic es, input int efa, input int efb, input logic eb);
      vec_t r;
      r.v = v;       r.rs = AW'(rs);   r.rsu = rsu;  r.rt = AW'(rt);
      r.rtu = rtu;   r.wen = wen;      r.lw = lw;    r.wa = AW'(wa);
      r.hilo = hilo; r.ms = ms;        r.mc = MW'(mc); r.fl = fl;
      r.e_stall = es; r.e_fa = FW'(efa); r.e_fb = FW'(efb); r.e_busy = eb;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive(input vec_t t);
      id_valid      = t.v;
      id_rs         = t.rs;
      id_rs_used    = t.rsu;
      id_rt         = t.rt;
      id_rt_used    = t.rtu;
      id_wen        = t.wen;
      id_lw         = t.lw;
      id_waddr      = t.wa;
      id_hilo       = t.hilo;
      id_mdu_start  = t.ms;
      id_mdu_cycles = t.mc;
      flush         = t.fl;
   endtask

   initial begin
      //        v  rs u  rt u wen lw wa hl ms mc fl | st fa fb bz
      // load-use: lw r5, then three stalled readers, then release
      tbl.push_back(mk(1, 0,0, 0,0, 1,1, 5, 0,0,0,0,  0,0,0,0));
      tbl.push_back(mk(1, 5,1, 6,1, 1,0, 8, 0,0,0,0,  1,0,0,0));
      tbl.push_back(mk(1, 5,1, 6,1, 1,0, 8, 0,0,0,0,  1,0,0,0));
      tbl.push_back(mk(1, 5,1, 6,1, 1,0, 8, 0,0,0,0,  1,0,0,0));
      tbl.push_back(mk(1, 5,1, 6,1, 1,0, 8, 0,0,0,0,  0,0,0,0));
      // forward priority: r7 written twice, r8 older
      tbl.push_back(mk(1, 0,0, 0,0, 1,0, 7, 0,0,0,0,  0,0,0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 1,0, 7, 0,0,0,0,  0,0,0,0));
      tbl.push_back(mk(1, 8,1, 7,1, 0,0, 0, 0,0,0,0,  0,3,1,0));
      tbl.push_back(mk(1, 8,1, 7,1, 0,0, 0, 0,0,0,0,  0,0,2,0));
      tbl.push_back(mk(1, 8,1, 7,1, 0,0, 0, 0,0,0,0,  0,0,3,0));
      tbl.push_back(mk(1, 8,1, 7,1, 0,0, 0, 0,0,0,0,  0,0,0,0));
      // r0 immunity, unused source, load seen from an older entry
      tbl.push_back(mk(1, 0,0, 0,0, 1,1, 0, 0,0,0,0,  0,0,0,0));
      tbl.push_back(mk(1, 0,1, 0,1, 0,0, 0, 0,0,0,0,  0,0,0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 1,1, 9, 0,0,0,0,  0,0,0,0));
      tbl.push_back(mk(1, 9,0, 3,1, 0,0, 0, 0,0,0,0,  0,0,0,0));
      tbl.push_back(mk(1, 9,1, 0,0, 0,0, 0, 0,0,0,0,  1,0,0,0));
      tbl.push_back(mk(1, 9,1, 0,0, 0,0, 0, 0,0,0,0,  1,0,0,0));
      tbl.push_back(mk(1, 9,1, 0,0, 0,0, 0, 0,0,0,0,  0,0,0,0));
      // MDU: 4-cycle mult then mfhi; then zero-latency launch
      tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0, 0,1,4,0,  0,0,0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 1,0,10, 1,0,0,0,  1,0,0,1));
      tbl.push_back(mk(1, 0,0, 0,0, 1,0,10, 1,0,0,0,  1,0,0,1));
      tbl.push_back(mk(1, 0,0, 0,0, 1,0,10, 1,0,0,0,  1,0,0,1));
      tbl.push_back(mk(1, 0,0, 0,0, 1,0,10, 1,0,0,0,  1,0,0,1));
      tbl.push_back(mk(1, 0,0, 0,0, 1,0,10, 1,0,0,0,  0,0,0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0, 0,1,0,0,  0,0,0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 1,0,10, 1,0,0,0,  0,0,0,0));
      // flush: pending load + busy MDU, flushed with a stalled reader
      tbl.push_back(mk(1, 0,0, 0,0, 1,1, 5, 0,0,0,0,  0,0,0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0, 0,1,5,0,  0,0,0,0));
      tbl.push_back(mk(1, 5,1, 0,0, 1,0,11, 0,0,0,1,  1,0,0,1));
      // flush drops a simultaneous register write and mult/div launch
      tbl.push_back(mk(1, 0,0, 0,0, 1,0,12, 0,0,0,1,  0,0,0,0));
      tbl.push_back(mk(1,12,1,11,1, 0,0, 0, 0,0,0,0,  0,0,0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0, 0,1,3,1,  0,0,0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0, 1,0,0,0,  0,0,0,0));
      // outputs during flush still reflect pre-edge state
      tbl.push_back(mk(1, 0,0, 0,0, 1,0,13, 0,0,0,0,  0,0,0,0));
      tbl.push_back(mk(1,13,1, 0,0, 0,0, 0, 0,0,0,1,  0,1,0,0));
      tbl.push_back(mk(1,13,1, 0,0, 0,0, 0, 0,0,0,0,  0,0,0,0));

      // ---------------- reset state ----------------
      drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      rst_n = 1'b0;
      #12;
      chk("reset.stall",     32'(stall),    32'd0);
      chk("reset.fwd_a",     32'(fwd_a),    32'd0);
      chk("reset.fwd_b",     32'(fwd_b),    32'd0);
      chk("reset.mdu_busy",  32'(mdu_busy), 32'd0);
      chk("reset.stall_cnt", stall_cnt,     32'd0);
      rst_n = 1'b1;

      // ---------------- table ----------------
      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk($sformatf("vec%0d.stall", i),    32'(stall),    32'(tbl[i].e_stall));
         chk($sformatf("vec%0d.fwd_a", i),    32'(fwd_a),    32'(tbl[i].e_fa));
         chk($sformatf("vec%0d.fwd_b", i),    32'(fwd_b),    32'(tbl[i].e_fb));
         chk($sformatf("vec%0d.mdu_busy", i), 32'(mdu_busy), 32'(tbl[i].e_busy));
      end
      @(negedge clk);
      drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      #1;
`ifdef HAZARD_PERF_EN
      chk("table.stall_cnt", stall_cnt, 32'd10);
`else
      chk("table.stall_cnt", stall_cnt, 32'd0);
`endif

      // ---------------- load-use stall count from a clean counter ----------
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      drive(mk(1, 0,0, 0,0, 1,1, 5, 0,0,0,0, 0,0,0,0));
      @(negedge clk);
      drive(mk(1, 5,1, 0,0, 0,0, 0, 0,0,0,0, 0,0,0,0));
      repeat (3) @(negedge clk);
      #1;
      chk("lu.stall_after", 32'(stall), 32'd0);
      chk("lu.fwd_a_after", 32'(fwd_a), 32'd0);
`ifdef HAZARD_PERF_EN
      chk("lu.stall_cnt", stall_cnt, 32'd3);
`else
      chk("lu.stall_cnt", stall_cnt, 32'd0);
`endif

      // ---------------- asynchronous reset mid-stall ----------------
      @(negedge clk);
      drive(mk(1, 0,0, 0,0, 0,0, 0, 0,1,9,0, 0,0,0,0));
      @(negedge clk);
      drive(mk(1, 0,0, 0,0, 1,1, 5, 0,0,0,0, 0,0,0,0));
      @(negedge clk);
      drive(mk(1, 5,1, 0,0, 0,0, 0, 1,0,0,0, 0,0,0,0));
      #1;
      chk("arst.stall_before", 32'(stall),    32'd1);
      chk("arst.busy_before",  32'(mdu_busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst.stall",     32'(stall),    32'd0);
      chk("arst.mdu_busy",  32'(mdu_busy), 32'd0);
      chk("arst.fwd_a",     32'(fwd_a),    32'd0);
      chk("arst.stall_cnt", stall_cnt,     32'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("arst.stall_after", 32'(stall),    32'd0);
      chk("arst.busy_after",  32'(mdu_busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
